wb_stage_gen: RTL and testbench

Parametrised writeback stage for the 5-stage LoongArch pipeline; next generation of the existing WB stage. It adds the following over the previous block:
- a valid/allowin handshake that can stall on a multi-cycle CSR access;
- a parametrised exception priority encoder;
- bad-vaddr capture;
- a post-flush drain counter.

It sits between MEM and the register file / CSR file, and drives the ID forwarding bus and the debug trace port.

---
 rtl/wb_stage_gen_if.sv | 38 +++
 rtl/wb_stage_gen.sv | 208 ++++++++++++++++++++
 tb/tb_wb_stage_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_gen_if.sv
// MEM -> WB instruction bus with valid/allowin handshake.
// master: MEM side (drives the instruction fields), slave: WB side.
interface wb_stage_gen_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CSRN_W  = 14,
    parameter int unsigned NUM_EXC = 6
);
    logic                mem_to_wb_valid;
    logic                wb_allowin;
    logic [XLEN-1:0]     in_pc;
    logic                in_rf_we;
    logic [RADDR_W-1:0]  in_rf_waddr;
    logic [XLEN-1:0]     in_rf_wdata;
    logic                in_csr_re;
    logic                in_csr_we;
    logic [CSRN_W-1:0]   in_csr_num;
    logic [XLEN-1:0]     in_csr_wmask;
    logic [XLEN-1:0]     in_csr_wvalue;
    logic                in_ertn;
    logic [NUM_EXC-1:0]  in_exc_vec;
    logic [8:0]          in_esubcode;
    logic [XLEN-1:0]     in_vaddr;

    modport master (
        output mem_to_wb_valid, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
               in_csr_re, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wvalue,
               in_ertn, in_exc_vec, in_esubcode, in_vaddr,
        input  wb_allowin
    );

    modport slave (
        input  mem_to_wb_valid, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
               in_csr_re, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wvalue,
               in_ertn, in_exc_vec, in_esubcode, in_vaddr,
        output wb_allowin
    );
endinterface

// File: rtl/wb_stage_gen.sv
// LoongArch writeback stage: valid/allowin handshake with CSR wait,
// exception priority encoding, flush commit and post-flush drain.
// Optional macro WB_BADV_CAPTURE_EN: registers the faulting vaddr on each
// exception commit; when undefined wb_vaddr is tied to zero.
module wb_stage_gen #(
    parameter int unsigned           XLEN          = 32,
    parameter int unsigned           RADDR_W       = 5,
    parameter int unsigned           CSRN_W        = 14,
    parameter int unsigned           NUM_EXC       = 6,
    parameter logic [NUM_EXC*6-1:0]  ECODE_TABLE   = {6'h9, 6'hd, 6'hc, 6'hb, 6'h8, 6'h0},
    parameter int unsigned           FLUSH_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                resetn,
    wb_stage_gen_if.slave       mem_if,
    output logic                csr_re,
    output logic                csr_we,
    output logic [CSRN_W-1:0]   csr_num,
    output logic [XLEN-1:0]     csr_wmask,
    output logic [XLEN-1:0]     csr_wvalue,
    input  logic [XLEN-1:0]     csr_rvalue,
    input  logic                csr_ready,
    output logic                fwd_we,
    output logic [RADDR_W-1:0]  fwd_waddr,
    output logic [XLEN-1:0]     fwd_wdata,
    output logic                wb_busy,
    output logic                wb_ex,
    output logic [5:0]          wb_ecode,
    output logic [8:0]          wb_esubcode,
    output logic [XLEN-1:0]     wb_ex_pc,
    output logic [XLEN-1:0]     wb_vaddr,
    output logic                ertn_flush,
    output logic [XLEN-1:0]     debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [RADDR_W-1:0]  debug_wb_rf_wnum,
    output logic [XLEN-1:0]     debug_wb_rf_wdata
);

    typedef enum logic [1:0] {S_RUN, S_CSR_WAIT, S_DRAIN} state_t;

    localparam logic [2:0] FB = 3'(FLUSH_BUBBLES);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                valid_q, valid_d;

    logic [XLEN-1:0]     pc_q;
    logic                rf_we_q;
    logic [RADDR_W-1:0]  rf_waddr_q;
    logic [XLEN-1:0]     rf_wdata_q;
    logic                csr_re_q;
    logic                csr_we_q;
    logic [CSRN_W-1:0]   csr_num_q;
    logic [XLEN-1:0]     csr_wmask_q;
    logic [XLEN-1:0]     csr_wvalue_q;
    logic                ertn_q;
    logic [NUM_EXC-1:0]  exc_vec_q;
    logic [8:0]          esubcode_q;

    logic                exc_any;
    logic                ready_go;
    logic                allowin;
    logic                retire;
    logic                flush;
    logic                accept;
    logic                csr_stall;
    logic [5:0]          ecode;

    assign exc_any   = |exc_vec_q;
    assign csr_stall = valid_q & (csr_re_q | csr_we_q) & ~exc_any & ~csr_ready;
    assign ready_go  = ~csr_stall;
    assign allowin   = (state_q == S_DRAIN) | ~valid_q | ready_go;
    assign retire    = valid_q & ready_go;
    assign wb_ex     = valid_q & exc_any;
    assign ertn_flush = valid_q & ertn_q & ~exc_any;
    assign flush     = wb_ex | ertn_flush;
    // A flushing cycle still shows allowin=1, but the incoming instruction
    // is younger than the flush and must be dropped.
    assign accept    = mem_if.mem_to_wb_valid & allowin & (state_q != S_DRAIN) & ~flush;

    assign mem_if.wb_allowin = allowin;

    // Lowest set exception bit selects its ecode slice; no bits gives 0.
    always_comb begin
        ecode = '0;
        for (int unsigned i = NUM_EXC; i > 0; i--) begin
            if (exc_vec_q[i-1]) ecode = ECODE_TABLE[(i-1)*6 +: 6];
        end
    end

    // Next-state for FSM, drain counter and valid bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (accept)                valid_d = 1'b1;
        else if (retire || flush)  valid_d = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (flush) begin
                    cnt_d = FB;
                    if (FB != 3'd0) state_d = S_DRAIN;
                end else if (csr_stall) begin
                    state_d = S_CSR_WAIT;
                end
            end
            S_CSR_WAIT: begin
                if (csr_ready) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (cnt_q <= 3'd1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State, counter and valid registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Holding registers for the instruction in WB, loaded on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q         <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            ertn_q       <= 1'b0;
            exc_vec_q    <= '0;
            esubcode_q   <= '0;
        end else if (accept) begin
            pc_q         <= mem_if.in_pc;
            rf_we_q      <= mem_if.in_rf_we;
            rf_waddr_q   <= mem_if.in_rf_waddr;
            rf_wdata_q   <= mem_if.in_rf_wdata;
            csr_re_q     <= mem_if.in_csr_re;
            csr_we_q     <= mem_if.in_csr_we;
            csr_num_q    <= mem_if.in_csr_num;
            csr_wmask_q  <= mem_if.in_csr_wmask;
            csr_wvalue_q <= mem_if.in_csr_wvalue;
            ertn_q       <= mem_if.in_ertn;
            exc_vec_q    <= mem_if.in_exc_vec;
            esubcode_q   <= mem_if.in_esubcode;
        end
    end

`ifdef WB_BADV_CAPTURE_EN
    logic [XLEN-1:0] vaddr_q;
    logic [XLEN-1:0] badv_q;

    // Faulting address latched with the instruction, captured on exception.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vaddr_q <= '0;
            badv_q  <= '0;
        end else begin
            if (accept) vaddr_q <= mem_if.in_vaddr;
            if (wb_ex)  badv_q  <= vaddr_q;
        end
    end

    assign wb_vaddr = badv_q;
`else
    logic unused_vaddr;
    assign unused_vaddr = ^mem_if.in_vaddr;
    assign wb_vaddr     = '0;
`endif

    assign csr_re      = valid_q & csr_re_q;
    assign csr_we      = valid_q & csr_we_q & ~exc_any;
    assign csr_num     = csr_num_q;
    assign csr_wmask   = csr_wmask_q;
    assign csr_wvalue  = csr_wvalue_q;

    assign fwd_we      = valid_q & rf_we_q & ~exc_any & ready_go;
    assign fwd_waddr   = rf_waddr_q;
    assign fwd_wdata   = csr_re ? csr_rvalue : rf_wdata_q;

    assign wb_busy     = valid_q & (exc_any | ertn_q);
    assign wb_ecode    = ecode;
    assign wb_esubcode = esubcode_q;
    assign wb_ex_pc    = pc_q;

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{fwd_we}};
    assign debug_wb_rf_wnum  = rf_waddr_q;
    assign debug_wb_rf_wdata = fwd_wdata;

endmodule

// File: tb/tb_wb_stage_gen.sv
// Directed bench for wb_stage_gen with a commit scoreboard.
module tb_wb_stage_gen;

    localparam int unsigned XLEN = 32, RADDR_W = 5, CSRN_W = 14, NUM_EXC = 6;

    logic clk, resetn;
    logic               csr_re, csr_we;
    logic [CSRN_W-1:0]  csr_num;
    logic [XLEN-1:0]    csr_wmask, csr_wvalue, csr_rvalue;
    logic               csr_ready;
    logic               fwd_we;
    logic [RADDR_W-1:0] fwd_waddr;
    logic [XLEN-1:0]    fwd_wdata;
    logic               wb_busy, wb_ex, ertn_flush;
    logic [5:0]         wb_ecode;
    logic [8:0]         wb_esubcode;
    logic [XLEN-1:0]    wb_ex_pc, wb_vaddr, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]         debug_wb_rf_we;
    logic [RADDR_W-1:0] debug_wb_rf_wnum;

    wb_stage_gen_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CSRN_W(CSRN_W), .NUM_EXC(NUM_EXC)) mif ();

    wb_stage_gen #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CSRN_W(CSRN_W), .NUM_EXC(NUM_EXC),
                   .FLUSH_BUBBLES(1)) dut (
        .clk(clk), .resetn(resetn), .mem_if(mif),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .csr_ready(csr_ready),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .wb_busy(wb_busy), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = register write, 1 = exception, 2 = ertn
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  ecode;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_badv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] pc, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic [5:0] ecode);
        exp_t e;
        e.kind = kind; e.pc = pc; e.waddr = waddr; e.wdata = wdata; e.ecode = ecode;
        sb.push_back(e);
    endtask

    // Pops the expected commit whenever the DUT signals one.
    task automatic monitor();
        exp_t e;
        logic [2:0] flags;
        if (fwd_we || wb_ex || ertn_flush) begin
            if (sb.size() == 0) begin
                chk("commit_unexpected", {fwd_we, wb_ex, ertn_flush}, 3'b000);
            end else begin
                e = sb.pop_front();
                flags = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
                chk("commit_kind", {fwd_we, wb_ex, ertn_flush}, flags);
                chk("commit_pc", debug_wb_pc, e.pc);
                if (e.kind == 0) begin
                    chk("wr_waddr", fwd_waddr, e.waddr);
                    chk("wr_wdata", fwd_wdata, e.wdata);
                    chk("wr_dbg_we", debug_wb_rf_we, 4'hf);
                    chk("wr_dbg_wnum", debug_wb_rf_wnum, e.waddr);
                    chk("wr_dbg_wdata", debug_wb_rf_wdata, e.wdata);
                end else if (e.kind == 1) begin
                    chk("ex_ecode", wb_ecode, e.ecode);
                    chk("ex_pc", wb_ex_pc, e.pc);
                    chk("ex_dbg_we", debug_wb_rf_we, 4'h0);
                    chk("ex_busy", wb_busy, 1'b1);
                end else begin
                    chk("ertn_busy", wb_busy, 1'b1);
                end
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        to_pos();
    endtask

    task automatic clr_in();
        mif.mem_to_wb_valid = 1'b0;
        mif.in_pc = '0; mif.in_rf_we = 1'b0; mif.in_rf_waddr = '0; mif.in_rf_wdata = '0;
        mif.in_csr_re = 1'b0; mif.in_csr_we = 1'b0; mif.in_csr_num = '0;
        mif.in_csr_wmask = '0; mif.in_csr_wvalue = '0; mif.in_ertn = 1'b0;
        mif.in_exc_vec = '0; mif.in_esubcode = '0; mif.in_vaddr = '0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_allowin"}, mif.wb_allowin, 1'b1);
        chk({pfx, "_csr_strobes"}, {csr_re, csr_we}, 2'b00);
        chk({pfx, "_csr_num"}, csr_num, 0);
        chk({pfx, "_csr_wmask"}, csr_wmask, 0);
        chk({pfx, "_csr_wvalue"}, csr_wvalue, 0);
        chk({pfx, "_fwd"}, {fwd_we, fwd_waddr, fwd_wdata}, 0);
        chk({pfx, "_exc"}, {wb_busy, wb_ex, ertn_flush, wb_ecode, wb_esubcode}, 0);
        chk({pfx, "_ex_pc"}, wb_ex_pc, 0);
        chk({pfx, "_vaddr"}, wb_vaddr, 0);
        chk({pfx, "_dbg_pc"}, debug_wb_pc, 0);
        chk({pfx, "_dbg"}, {debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
    endtask

    initial begin
        // Reset state, with a nonzero CSR read value present.
        resetn = 1'b0;
        clr_in();
        csr_rvalue = 32'h1234_5678;
        csr_ready  = 1'b0;
        exp_badv   = '0;
        #12;
        chk_reset_outputs("rst");
        resetn    = 1'b1;
        csr_ready = 1'b1;
        to_pos();

        // 1: back-to-back ALU writes.
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0000;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd3; mif.in_rf_wdata = 32'h0000_0011;
        push(0, 32'h1c00_0000, 5'd3, 32'h0000_0011, 6'h0);
        at_neg(); chk("t1_allowin0", mif.wb_allowin, 1'b1); to_pos();
        mif.in_pc = 32'h1c00_0004; mif.in_rf_waddr = 5'd4; mif.in_rf_wdata = 32'h0000_0022;
        push(0, 32'h1c00_0004, 5'd4, 32'h0000_0022, 6'h0);
        at_neg(); chk("t1_allowin1", mif.wb_allowin, 1'b1); chk("t1_fwd_we1", fwd_we, 1'b1); to_pos();
        clr_in();
        at_neg(); chk("t1_fwd_we2", fwd_we, 1'b1); chk("t1_allowin2", mif.wb_allowin, 1'b1); to_pos();

        // 2: csrrd stalled three cycles, younger instruction waiting behind it.
        csr_ready = 1'b0; csr_rvalue = 32'hdead_beef;
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0010; mif.in_csr_re = 1'b1;
        mif.in_csr_num = 14'h5; mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd7;
        push(0, 32'h1c00_0010, 5'd7, 32'hdead_beef, 6'h0);
        cyc();
        clr_in();
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0014;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd9; mif.in_rf_wdata = 32'h0000_0099;
        push(0, 32'h1c00_0014, 5'd9, 32'h0000_0099, 6'h0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t2_allowin_wait", mif.wb_allowin, 1'b0);
            chk("t2_fwd_we_wait", fwd_we, 1'b0);
            chk("t2_csr_re", csr_re, 1'b1);
            chk("t2_csr_num", csr_num, 14'h5);
            chk("t2_csr_we", csr_we, 1'b0);
            to_pos();
        end
        csr_ready = 1'b1;
        at_neg(); chk("t2_allowin_ready", mif.wb_allowin, 1'b1); chk("t2_csr_we_rdy", csr_we, 1'b0); to_pos();
        clr_in();
        cyc();

        // 3: exception, younger instruction dropped on the flush and drain cycles.
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0100; mif.in_exc_vec = 6'b010100;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd5; mif.in_rf_wdata = 32'h55;
        push(1, 32'h1c00_0100, 5'd0, 32'h0, 6'hb);
        cyc();
        clr_in();
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0200;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd6; mif.in_rf_wdata = 32'h66;
        at_neg(); chk("t3_fwd_we_ex", fwd_we, 1'b0); to_pos();
        at_neg(); chk("t3_drain_allowin", mif.wb_allowin, 1'b1); chk("t3_ex_pulse", wb_ex, 1'b0); to_pos();
        clr_in();
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0300;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd8; mif.in_rf_wdata = 32'h88;
        push(0, 32'h1c00_0300, 5'd8, 32'h88, 6'h0);
        cyc();
        clr_in();
        cyc();
        chk("t3_sb_empty", sb.size(), 0);

        // 4: ertn alone, then ertn with highest-priority exception bit.
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0400; mif.in_ertn = 1'b1;
        push(2, 32'h1c00_0400, 5'd0, 32'h0, 6'h0);
        cyc();
        clr_in();
        at_neg(); chk("t4_ertn_no_ex", wb_ex, 1'b0); to_pos();
        cyc();
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0500; mif.in_ertn = 1'b1;
        mif.in_exc_vec = 6'b000001;
        push(1, 32'h1c00_0500, 5'd0, 32'h0, 6'h0);
        cyc();
        clr_in();
        at_neg(); chk("t4_ertn_masked", ertn_flush, 1'b0); to_pos();
        cyc();

        // 5: bad vaddr capture on ALE, unchanged by a later normal write.
`ifdef WB_BADV_CAPTURE_EN
        exp_badv = 32'h1c00_0123;
`endif
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0600; mif.in_exc_vec = 6'b100000;
        mif.in_vaddr = 32'h1c00_0123;
        push(1, 32'h1c00_0600, 5'd0, 32'h0, 6'h9);
        cyc();
        clr_in();
        cyc();
        at_neg(); chk("t5_badv", wb_vaddr, exp_badv); to_pos();
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0700; mif.in_vaddr = 32'hffff_0000;
        mif.in_rf_we = 1'b1; mif.in_rf_waddr = 5'd10; mif.in_rf_wdata = 32'haa;
        push(0, 32'h1c00_0700, 5'd10, 32'haa, 6'h0);
        cyc();
        clr_in();
        at_neg(); chk("t5_badv_commit", wb_vaddr, exp_badv); to_pos();
        at_neg(); chk("t5_badv_hold", wb_vaddr, exp_badv); to_pos();

        // 6: reset while a CSR write waits on csr_ready.
        csr_ready = 1'b0;
        mif.mem_to_wb_valid = 1'b1; mif.in_pc = 32'h1c00_0800; mif.in_csr_we = 1'b1;
        mif.in_csr_num = 14'h10; mif.in_csr_wmask = 32'hffff_ffff; mif.in_csr_wvalue = 32'h0000_abcd;
        cyc();
        clr_in();
        at_neg();
        chk("t6_csr_we", csr_we, 1'b1);
        chk("t6_csr_num", csr_num, 14'h10);
        chk("t6_csr_wvalue", csr_wvalue, 32'h0000_abcd);
        chk("t6_allowin", mif.wb_allowin, 1'b0);
        to_pos();
        at_neg();
        chk("t6_csr_we_held", csr_we, 1'b1);
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("t6_rst");
        to_pos();
        csr_ready = 1'b1;
        #2 resetn = 1'b1;
        at_neg(); chk("t6_no_csr_we", csr_we, 1'b0); chk("t6_allowin_post", mif.wb_allowin, 1'b1); to_pos();
        at_neg(); chk("t6_no_csr_we2", csr_we, 1'b0); to_pos();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
